// File: rtl/full_subtractor.sv
// Registered ripple-borrow subtractor: {B,D} = X - Y - Z, one pipeline stage.
// The borrow chain is an explicit generate loop of 1-bit full-subtractor cells.
module full_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Z,
  output logic             out_valid,
  output logic [WIDTH-1:0] D,
  output logic             B
);

  logic [WIDTH:0]   borrow_s;
  logic [WIDTH-1:0] diff_s;

  logic [WIDTH-1:0] d_d, d_q;
  logic             b_d, b_q;
  logic             valid_d, valid_q;

  assign borrow_s[0] = Z;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i = i + 1) begin : g_cell
      assign diff_s[i]       = X[i] ^ Y[i] ^ borrow_s[i];
      assign borrow_s[i+1]   = (~X[i] & Y[i]) | (~X[i] & borrow_s[i]) | (Y[i] & borrow_s[i]);
    end
  endgenerate

  // Capture a new result only on valid input; otherwise hold, so unqualified operands never reach D/B.
  always_comb begin
    d_d     = d_q;
    b_d     = b_q;
    valid_d = in_valid;
    if (in_valid) begin
      d_d = diff_s;
      b_d = borrow_s[WIDTH];
    end else begin
      d_d = d_q;
      b_d = b_q;
    end
  end

  // Result and valid registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q     <= {WIDTH{1'b0}};
      b_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  assign D         = d_q;
  assign B         = b_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Scoreboard bench for full_subtractor: a 1-bit and an 8-bit instance, directed
// vectors with hand-computed results plus an 8-bit random regression.
module tb_full_subtractor;

  logic       clk;
  logic       rst;

  logic       v1, x1, y1, z1;
  logic       ov1, d1, b1;

  logic       v8, z8;
  logic [7:0] x8, y8;
  logic       ov8, b8;
  logic [7:0] d8;

  int n_tests;
  int n_fail;

  // Expected {B,D} per instance, pushed when a valid input is driven
  logic [1:0] q1[$];
  logic [8:0] q8[$];

  full_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .X(x1), .Y(y1), .Z(z1),
    .out_valid(ov1), .D(d1), .B(b1)
  );

  full_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .X(x8), .Y(y8), .Z(z8),
    .out_valid(ov8), .D(d8), .B(b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a result
  always @(negedge clk) begin
    if (ov1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("w1_unexpected_valid", {8'h00, ov1}, 9'h000);
      end else begin
        check("w1_result", {7'h00, b1, d1}, {7'h00, q1.pop_front()});
      end
    end
    if (ov8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("w8_unexpected_valid", {8'h00, ov8}, 9'h000);
      end else begin
        check("w8_result", {b8, d8}, q8.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive1(input logic x, input logic y, input logic z, input logic [1:0] exp_bd);
    step();
    v1 = 1'b1; x1 = x; y1 = y; z1 = z;
    q1.push_back(exp_bd);
  endtask

  task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic z, input logic [8:0] exp_bd);
    step();
    v8 = 1'b1; x8 = x; y8 = y; z8 = z;
    q8.push_back(exp_bd);
  endtask

  // Hand-computed {B,D} for the 1-bit cell, indexed by {X,Y,Z}
  logic [1:0] cell_tbl [0:7];

  initial begin
    logic [7:0] rx, ry;
    logic       rz;
    logic [8:0] full;

    n_tests = 0;
    n_fail  = 0;
    cell_tbl[0] = 2'b00; cell_tbl[1] = 2'b11; cell_tbl[2] = 2'b11; cell_tbl[3] = 2'b10;
    cell_tbl[4] = 2'b01; cell_tbl[5] = 2'b00; cell_tbl[6] = 2'b00; cell_tbl[7] = 2'b11;

    rst = 1'b1;
    v1 = 1'b0; x1 = 1'b0; y1 = 1'b0; z1 = 1'b0;
    v8 = 1'b0; x8 = 8'h00; y8 = 8'h00; z8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("w1_reset", {6'h00, ov1, b1, d1}, 9'h000);
    check("w8_reset_d_b", {b8, d8}, 9'h000);
    check("w8_reset_valid", {8'h00, ov8}, 9'h000);
    step();
    rst = 1'b0;

    // 1: ordered vectors
    drive1(1'b0, 1'b0, 1'b0, 2'b00);
    drive1(1'b1, 1'b0, 1'b0, 2'b01);
    drive1(1'b1, 1'b1, 1'b0, 2'b00);
    drive1(1'b1, 1'b1, 1'b1, 2'b11);

    // 2: exhaustive sweep
    for (int k = 0; k < 8; k++) begin
      logic [2:0] xyz;
      xyz = 3'(k);
      drive1(xyz[2], xyz[1], xyz[0], cell_tbl[k]);
    end
    step();
    v1 = 1'b0;

    // 3: 8-bit boundaries
    drive8(8'h00, 8'h01, 1'b0, 9'h1FF);
    drive8(8'h80, 8'h7F, 1'b1, 9'h000);
    drive8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    drive8(8'h00, 8'hFF, 1'b1, 9'h100);
    drive8(8'hA5, 8'h25, 1'b0, 9'h080);
    step();
    v8 = 1'b0;
    repeat (2) step();

    // 4: hold with garbage operands while invalid
    drive1(1'b1, 1'b0, 1'b0, 2'b01);
    step();
    v1 = 1'b0; x1 = 1'b0; y1 = 1'b1; z1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold_valid_low", {8'h00, ov1}, 9'h000);
    check("hold_d_b", {7'h00, b1, d1}, 9'h001);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("hold_d_b_later", {7'h00, b1, d1}, 9'h001);

    // 5: reset on the same edge as a valid input
    step();
    v1 = 1'b1; x1 = 1'b1; y1 = 1'b1; z1 = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_w1", {6'h00, ov1, b1, d1}, 9'h000);
    check("midreset_w8", {b8, d8}, 9'h000);
    #3;
    rst = 1'b0;
    v1 = 1'b1; x1 = 1'b1; y1 = 1'b0; z1 = 1'b0;
    q1.push_back(2'b01);
    step();
    v1 = 1'b0;

    // 6: random 8-bit regression, back-to-back
    for (int k = 0; k < 1000; k++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rz = 1'($urandom_range(0, 1));
      full = {1'b0, rx} - {1'b0, ry} - {8'h00, rz};
      drive8(rx, ry, rz, full);
    end
    step();
    v8 = 1'b0;
    repeat (3) step();

    check("w1_scoreboard_drained", 9'(q1.size()), 9'h000);
    check("w8_scoreboard_drained", 9'(q8.size()), 9'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
